alu_multicycle: RTL



---
 rtl/lc3_alu_pkg.sv | 31 +++
 rtl/alu_multicycle_mul_shift_add.sv | 46 ++++
 rtl/alu_multicycle.sv | 103 ++++++++++
 3 files changed

// File: rtl/lc3_alu_pkg.sv
// Shared types and helpers for the LC-3 execute-stage ALU.
package lc3_alu_pkg;

    localparam int NZP_W = 64;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_AND  = 3'b001,
        OP_NOT  = 3'b010,
        OP_PASS = 3'b011,
        OP_MUL  = 3'b100,
        OP_SUB  = 3'b101
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } alu_state_t;

    // Callers sign-extend into NZP_W bits, which keeps both sign and zero-ness.
    function automatic logic [2:0] nzp_of(input logic [NZP_W-1:0] v);
        if (v[NZP_W-1])
            return 3'b100;
        else if (v == '0)
            return 3'b010;
        else
            return 3'b001;
    endfunction

endpackage

// File: rtl/alu_multicycle_mul_shift_add.sv
// Iterative shift-add multiplier datapath; sequenced by alu_multicycle.
module mul_shift_add #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_acc_next,
    output logic             o_last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_addend;

    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign o_acc_next = r_acc + w_addend;
    assign o_last     = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_step) begin
            r_acc    <= o_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle ops plus an iterative MUL, start/done handshake.
module alu_multicycle
    import lc3_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       nzp
);

    alu_state_t       r_state;
    alu_state_t       w_state_nxt;
    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic             w_wr;
    logic [WIDTH-1:0] w_single;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_wdata;

    mul_shift_add #(.WIDTH(WIDTH)) u_mul (
        .i_clk      (Clk),
        .i_rst      (Reset),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_a        (A),
        .i_b        (B),
        .o_acc_next (w_acc_next),
        .o_last     (w_last)
    );

    always_comb begin
        case (op)
            OP_ADD:  w_single = A + B;
            OP_AND:  w_single = A & B;
            OP_NOT:  w_single = ~A;
            OP_SUB:  w_single = A - B;
            default: w_single = A;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_wr        = 1'b0;
        w_wdata     = w_single;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        w_load      = 1'b1;
                        w_state_nxt = MUL;
                    end else begin
                        w_wr        = 1'b1;
                        w_state_nxt = DONE;
                    end
                end
            end
            MUL: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_wr        = 1'b1;
                    w_wdata     = w_acc_next;
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            result <= '0;
            nzp    <= 3'b010;
        end else if (w_wr) begin
            result <= w_wdata;
            nzp    <= nzp_of(NZP_W'($signed(w_wdata)));
        end
    end

    assign ready = (r_state == IDLE);
    assign busy  = (r_state == MUL);
    assign done  = (r_state == DONE);

endmodule
